// File: rtl/eth_type_classifier.sv
// eth_type_classifier
// Streaming L2 header parser. Skips DA/SA and up to MAX_VLAN 802.1Q/802.1ad
// tags, matches the inner ethertype against a runtime table and emits one
// classification record per frame.
//
// Handshake semantics (both ports): a transfer happens on a rising clock edge
// where valid and ready are both high. A producer holding valid high keeps its
// payload stable until the transfer. in_ready is low only while a record is
// waiting in RESULT (and while rst is high). out_valid and all out_* fields
// are held stable from the edge they are loaded until the edge of the
// out_valid & out_ready transfer.
module eth_type_classifier #(
    parameter int NUM_CLASS = 4,
    parameter int MAX_VLAN  = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [7:0]                     in_data,
    input  logic                           in_sof,
    input  logic                           in_eof,
    input  logic [16*NUM_CLASS-1:0]        cfg_types,
    input  logic [NUM_CLASS-1:0]           cfg_en,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_CLASS:0]             out_class,
    output logic [$clog2(NUM_CLASS+1)-1:0] out_idx,
    output logic [$clog2(MAX_VLAN+1)-1:0]  out_vlan_cnt,
    output logic [11:0]                    out_vid,
    output logic                           out_err
);

    localparam int IDX_W = $clog2(NUM_CLASS + 1);
    localparam int VC_W  = $clog2(MAX_VLAN + 1);

    localparam logic [IDX_W-1:0]   IDX_OTHER   = IDX_W'(NUM_CLASS);
    localparam logic [NUM_CLASS:0] CLASS_OTHER = {1'b1, {NUM_CLASS{1'b0}}};
    localparam logic [NUM_CLASS:0] CLASS_ONE   = {{NUM_CLASS{1'b0}}, 1'b1};
    localparam logic [VC_W-1:0]    VLAN_MAX    = VC_W'(MAX_VLAN);
    localparam logic [VC_W-1:0]    VLAN_ONE    = VC_W'(1);

    localparam logic [15:0] TPID_CTAG = 16'h8100;
    localparam logic [15:0] TPID_STAG = 16'h88A8;

    // Last DA/SA byte arrives while byte_cnt holds 11 (the sof byte counts as 1).
    localparam logic [3:0] MAC_LAST_CNT = 4'd11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MAC     = 3'd1,
        TYPE_HI = 3'd2,
        TYPE_LO = 3'd3,
        TAG     = 3'd4,
        RESULT  = 3'd5,
        DRAIN   = 3'd6
    } state_t;

    state_t state;
    state_t state_nxt;

    // Parse context for the frame in flight
    logic [3:0]      byte_cnt;
    logic [7:0]      type_hi;
    logic            tci_sel;     // 0: first TCI byte next, 1: second
    logic [3:0]      tci_hi;      // VID[11:8] from the first TCI byte
    logic [VC_W-1:0] vlan_cnt;
    logic [11:0]     vid;
    logic            eof_seen;    // the frame's eof beat was consumed before RESULT

    // Decode of the current beat
    logic            beat;
    logic [15:0]     cur_type;
    logic            is_tpid;
    logic            take_tag;
    logic            restart;
    logic            early_end;
    logic            rec_load;
    logic            rec_err;
    logic            rec_eof;

    // Table lookup result for cur_type
    logic [IDX_W-1:0]   match_idx;
    logic [NUM_CLASS:0] match_class;

    assign in_ready = !rst && (state != RESULT);
    assign beat     = in_valid && in_ready;
    assign cur_type = {type_hi, in_data};
    assign is_tpid  = (cur_type == TPID_CTAG) || (cur_type == TPID_STAG);
    assign take_tag = is_tpid && (vlan_cnt < VLAN_MAX);

    // Priority match: lowest enabled entry whose ethertype equals cur_type wins
    always_comb begin
        match_idx = IDX_OTHER;
        for (int i = NUM_CLASS - 1; i >= 0; i--) begin
            if (cfg_en[i] && (cfg_types[16*i +: 16] == cur_type)) begin
                match_idx = IDX_W'(i);
            end
        end
        match_class = CLASS_ONE << match_idx;
    end

    // Next-state logic and record-load decode
    always_comb begin
        state_nxt = state;
        restart   = 1'b0;
        early_end = 1'b0;
        rec_load  = 1'b0;
        rec_err   = 1'b0;
        rec_eof   = 1'b0;

        if (beat && in_sof) begin
            // A start-of-frame beat always begins a fresh parse; whatever
            // frame was in progress is dropped without a record.
            restart = 1'b1;
            if (in_eof) begin
                early_end = 1'b1;
            end else begin
                state_nxt = MAC;
            end
        end else begin
            case (state)
                IDLE: begin
                    // bytes outside a frame are discarded
                end
                MAC: begin
                    if (beat) begin
                        if (in_eof) begin
                            early_end = 1'b1;
                        end else if (byte_cnt == MAC_LAST_CNT) begin
                            state_nxt = TYPE_HI;
                        end
                    end
                end
                TYPE_HI: begin
                    if (beat) begin
                        if (in_eof) begin
                            early_end = 1'b1;
                        end else begin
                            state_nxt = TYPE_LO;
                        end
                    end
                end
                TYPE_LO: begin
                    if (beat) begin
                        if (take_tag) begin
                            // a tag whose TCI never arrives is a truncated header
                            if (in_eof) begin
                                early_end = 1'b1;
                            end else begin
                                state_nxt = TAG;
                            end
                        end else begin
                            state_nxt = RESULT;
                            rec_load  = 1'b1;
                            rec_eof   = in_eof;
                        end
                    end
                end
                TAG: begin
                    if (beat) begin
                        if (in_eof) begin
                            early_end = 1'b1;
                        end else if (tci_sel) begin
                            state_nxt = TYPE_HI;
                        end
                    end
                end
                RESULT: begin
                    if (out_ready) begin
                        state_nxt = eof_seen ? IDLE : DRAIN;
                    end
                end
                DRAIN: begin
                    if (beat && in_eof) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end

        if (early_end) begin
            state_nxt = RESULT;
            rec_load  = 1'b1;
            rec_err   = 1'b1;
            rec_eof   = 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Parse context: byte counter, ethertype high byte, tag count and VID
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt <= '0;
            type_hi  <= '0;
            tci_sel  <= 1'b0;
            tci_hi   <= '0;
            vlan_cnt <= '0;
            vid      <= '0;
        end else if (restart) begin
            byte_cnt <= 4'd1;
            tci_sel  <= 1'b0;
            vlan_cnt <= '0;
            vid      <= '0;
        end else if (beat) begin
            case (state)
                MAC: begin
                    byte_cnt <= byte_cnt + 4'd1;
                end
                TYPE_HI: begin
                    type_hi <= in_data;
                end
                TYPE_LO: begin
                    if (take_tag && !in_eof) begin
                        vlan_cnt <= vlan_cnt + VLAN_ONE;
                        tci_sel  <= 1'b0;
                    end
                end
                TAG: begin
                    tci_sel <= !tci_sel;
                    if (!tci_sel) begin
                        tci_hi <= in_data[3:0];
                    end else if (vlan_cnt == VLAN_ONE) begin
                        // only the outermost tag's VID is reported
                        vid <= {tci_hi, in_data};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output record: loaded when a frame resolves, held until accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_class    <= '0;
            out_idx      <= '0;
            out_vlan_cnt <= '0;
            out_vid      <= '0;
            out_err      <= 1'b0;
            eof_seen     <= 1'b0;
        end else if (rec_load) begin
            out_valid    <= 1'b1;
            out_err      <= rec_err;
            out_idx      <= rec_err ? IDX_OTHER : match_idx;
            out_class    <= rec_err ? CLASS_OTHER : match_class;
            // a sof+eof beat truncates the new frame before any tag is seen
            out_vlan_cnt <= restart ? '0 : vlan_cnt;
            out_vid      <= restart ? '0 : vid;
            eof_seen     <= rec_eof;
        end else if ((state == RESULT) && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_eth_type_classifier.sv
// tb_eth_type_classifier
// Directed frames against a frame-level reference model. Each frame is turned
// into its expected record (or none) by walking the byte list, then driven;
// a compare process checks every cycle out_valid is high.
module tb_eth_type_classifier;

    localparam int NUM_CLASS = 4;
    localparam int MAX_VLAN  = 2;
    localparam int IDX_W     = $clog2(NUM_CLASS + 1);
    localparam int VC_W      = $clog2(MAX_VLAN + 1);

    typedef struct packed {
        logic             err;
        logic [IDX_W-1:0] idx;
        logic [VC_W-1:0]  vlan;
        logic [11:0]      vid;
    } rec_t;

    localparam int REC_W = $bits(rec_t);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [7:0]              in_data  = '0;
    logic                    in_sof   = 1'b0;
    logic                    in_eof   = 1'b0;
    logic [16*NUM_CLASS-1:0] cfg_types = '0;
    logic [NUM_CLASS-1:0]    cfg_en    = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b1;
    logic [NUM_CLASS:0]      out_class;
    logic [IDX_W-1:0]        out_idx;
    logic [VC_W-1:0]         out_vlan_cnt;
    logic [11:0]             out_vid;
    logic                    out_err;

    eth_type_classifier #(.NUM_CLASS(NUM_CLASS), .MAX_VLAN(MAX_VLAN)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_sof       (in_sof),
        .in_eof       (in_eof),
        .cfg_types    (cfg_types),
        .cfg_en       (cfg_en),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_class    (out_class),
        .out_idx      (out_idx),
        .out_vlan_cnt (out_vlan_cnt),
        .out_vid      (out_vid),
        .out_err      (out_err)
    );

    // ---------------- scoreboard state ----------------
    logic [REC_W-1:0] exp_q[$];
    logic [7:0]       fq[$];
    int checks   = 0;
    int errors   = 0;
    int n_pushed = 0;
    int n_popped = 0;
    int w;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic rec_t mk(input logic e, input int idx, input int vl, input int vd);
        rec_t r;
        r.err  = e;
        r.idx  = IDX_W'(idx);
        r.vlan = VC_W'(vl);
        r.vid  = 12'(vd);
        return r;
    endfunction

    // Reference model: walk the frame bytes in fq. Returns 1 when the frame
    // yields a record; has_eof says whether the frame was terminated by eof
    // (otherwise it is cut short by the next sof).
    function automatic bit model(input bit has_eof, output rec_t r);
        int          pos  = 12;
        int          tags = 0;
        int          vidv = 0;
        int          n    = fq.size();
        logic [15:0] t;
        r = '0;
        for (int k = 0; k <= MAX_VLAN; k++) begin
            if (n < pos + 2) begin
                if (!has_eof) return 1'b0;
                r = mk(1'b1, NUM_CLASS, tags, vidv);
                return 1'b1;
            end
            t = {fq[pos], fq[pos+1]};
            if ((t == 16'h8100 || t == 16'h88A8) && tags < MAX_VLAN) begin
                if (n < pos + 4) begin
                    if (!has_eof) return 1'b0;
                    r = mk(1'b1, NUM_CLASS, (n > pos + 2) ? tags + 1 : tags, vidv);
                    return 1'b1;
                end
                if (tags == 0) vidv = int'({fq[pos+2][3:0], fq[pos+3]});
                tags++;
                pos += 4;
            end else begin
                int idx = NUM_CLASS;
                for (int i = NUM_CLASS - 1; i >= 0; i--) begin
                    if (cfg_en[i] && cfg_types[16*i +: 16] == t) idx = i;
                end
                r = mk(1'b0, idx, tags, vidv);
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    // ---------------- frame building / driver tasks ----------------
    task automatic new_frame();
        fq.delete();
        for (int k = 0; k < 12; k++) fq.push_back(8'(8'h10 + k));
    endtask

    task automatic add(input logic [7:0] b);
        fq.push_back(b);
    endtask

    task automatic add_payload(input int n);
        for (int k = 0; k < n; k++) fq.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic drive_byte(input logic [7:0] d, input logic s, input logic e);
        int wc = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = s;
        in_eof   = e;
        while (!in_ready && wc < 200) begin
            @(posedge clk);
            #1;
            wc++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles expected 1", wc);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_eof   = 1'b0;
    endtask

    task automatic send_frame(input bit has_eof, input int lat_idx);
        rec_t r;
        bit   em;
        em = model(has_eof, r);
        if (em) begin
            exp_q.push_back(REC_W'(r));
            n_pushed++;
        end
        for (int k = 0; k < fq.size(); k++) begin
            drive_byte(fq[k], k == 0, has_eof && (k == fq.size() - 1));
            if (k == lat_idx) chk("latency_out_valid", out_valid, 1);
        end
    endtask

    task automatic pin(input string name, input bit has_eof, input rec_t exp);
        rec_t r;
        bit   em;
        em = model(has_eof, r);
        chk({name, "_emit"}, em, 1);
        chk(name, r, exp);
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        rec_t               e;
        logic [NUM_CLASS:0] ec;
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_record: got idx=%0d err=%0d expected no record", out_idx, out_err);
            end else begin
                e  = rec_t'(exp_q[0]);
                ec = '0;
                ec[e.idx] = 1'b1;
                chk("rec_err", out_err, e.err);
                chk("rec_idx", out_idx, e.idx);
                chk("rec_class", out_class, ec);
                chk("rec_vlan_cnt", out_vlan_cnt, e.vlan);
                chk("rec_vid", out_vid, e.vid);
                chk("in_ready_while_record", in_ready, 0);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    n_popped++;
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        rec_t nr;
        bit   nem;
        cfg_types = {16'h0000, 16'h0000, 16'h86DD, 16'h0800};
        cfg_en    = 4'b0011;

        // reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_class", out_class, 0);
        chk("reset_out_idx", out_idx, 0);
        chk("reset_out_vlan_cnt", out_vlan_cnt, 0);
        chk("reset_out_vid", out_vid, 0);
        chk("reset_out_err", out_err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // T1: untagged IPv4, record on the TYPE_LO beat (byte index 13)
        new_frame(); add(8'h08); add(8'h00); add_payload(46);
        pin("t1_model", 1'b1, mk(1'b0, 0, 0, 0));
        send_frame(1'b1, 13);

        // T2: one C-tag, IPv6
        new_frame(); add(8'h81); add(8'h00); add(8'h01); add(8'h23);
        add(8'h86); add(8'hDD); add_payload(20);
        pin("t2_model", 1'b1, mk(1'b0, 1, 1, 12'h123));
        send_frame(1'b1, -1);

        // T3: S-tag + C-tag, third TPID is the ethertype
        new_frame(); add(8'h88); add(8'hA8); add(8'h00); add(8'h0A);
        add(8'h81); add(8'h00); add(8'h0F); add(8'hFF);
        add(8'h81); add(8'h00); add_payload(10);
        pin("t3_model", 1'b1, mk(1'b0, 4, 2, 12'h00A));
        send_frame(1'b1, -1);

        // T4: consumer stalls 5 cycles, then a back-to-back frame
        new_frame(); add(8'h08); add(8'h00); add_payload(30);
        out_ready = 1'b0;
        fork
            send_frame(1'b1, -1);
            begin
                w = 0;
                while (!out_valid && w < 100) begin
                    @(posedge clk);
                    #1;
                    w++;
                end
                chk("t4_valid_seen", out_valid, 1);
                repeat (5) begin
                    @(posedge clk);
                    #1;
                    chk("t4_stall_in_ready", in_ready, 0);
                    chk("t4_stall_valid", out_valid, 1);
                end
                out_ready = 1'b1;
            end
        join
        new_frame(); add(8'h86); add(8'hDD); add_payload(10);
        send_frame(1'b1, -1);

        // T5: eof on the 10th byte
        fq.delete();
        for (int k = 0; k < 10; k++) fq.push_back(8'(8'h20 + k));
        pin("t5_model", 1'b1, mk(1'b1, 4, 0, 0));
        send_frame(1'b1, -1);

        // T5: frame abandoned mid-MAC by a new sof, then a clean frame
        fq.delete();
        for (int k = 0; k < 8; k++) fq.push_back(8'(8'h30 + k));
        nem = model(1'b0, nr);
        chk("t5_abandon_model", nem, 0);
        send_frame(1'b0, -1);
        new_frame(); add(8'h08); add(8'h00); add_payload(5);
        send_frame(1'b1, -1);

        // classified frame cut in DRAIN by the next sof
        new_frame(); add(8'h86); add(8'hDD); add_payload(6);
        send_frame(1'b0, -1);
        new_frame(); add(8'h08); add(8'h00); add_payload(4);
        send_frame(1'b1, -1);

        // single-beat sof+eof frame
        fq.delete(); add(8'h55);
        pin("sof_eof_model", 1'b1, mk(1'b1, 4, 0, 0));
        send_frame(1'b1, -1);

        // eof inside the first tag's TCI
        new_frame(); add(8'h81); add(8'h00); add(8'h05);
        pin("tag_eof_model", 1'b1, mk(1'b1, 4, 1, 0));
        send_frame(1'b1, -1);

        // T6: duplicate entries, enable picks the winner
        cfg_types = {16'h0000, 16'h0800, 16'h86DD, 16'h0800};
        cfg_en    = 4'b0100;
        new_frame(); add(8'h08); add(8'h00); add_payload(8);
        pin("t6_model", 1'b1, mk(1'b0, 2, 0, 0));
        send_frame(1'b1, -1);
        cfg_en = 4'b0101;
        new_frame(); add(8'h08); add(8'h00); add_payload(8);
        pin("t6_lowest_model", 1'b1, mk(1'b0, 0, 0, 0));
        send_frame(1'b1, -1);

        // T6: reset pulse mid-MAC drops the frame
        fq.delete();
        for (int k = 0; k < 6; k++) fq.push_back(8'(8'h40 + k));
        send_frame(1'b0, -1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_out_valid", out_valid, 0);
        rst = 1'b0;
        cfg_en = 4'b0111;
        new_frame(); add(8'h86); add(8'hDD); add_payload(8);
        send_frame(1'b1, -1);

        // drain outstanding records
        w = 0;
        while (exp_q.size() != 0 && w < 200) begin
            @(posedge clk);
            w++;
        end
        repeat (4) @(posedge clk);
        chk("queue_empty", exp_q.size(), 0);
        chk("record_count", n_popped, n_pushed);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
